iram_boot: RTL and testbench

IRAM_BOOT -- requirements
Module: iram_boot

---
 rtl/iram_boot.sv | 176 +++++++++++++++++
 tb/tb_iram_boot.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iram_boot.sv
// iram_boot: boot-loadable instruction RAM.
// After reset the memory is zeroed one word per cycle (CLEAR). The RUN state then
// serves registered instruction fetches. An LD_START pulse enters LOAD, which
// assembles a little-endian byte stream into words written from index 0.
// Optional feature macro: IRAM_BOOT_CSUM_EN adds a modulo-256 byte checksum on CSUM.
`timescale 1ns/1ps

module iram_boot #(
    parameter int IW = 16,
    parameter int AW = 8
) (
    input  logic                         CLK,
    input  logic                         RESET_N,
    input  logic [AW-1:0]                ADDR,
    output logic [IW-1:0]                Q,
    output logic                         MISALIGN,
    output logic                         BUSY,
    input  logic                         LD_START,
    input  logic                         LD_VALID,
    input  logic [7:0]                   LD_DATA,
    input  logic                         LD_LAST,
    output logic                         LD_READY,
    output logic                         LOAD_ERR,
    output logic [AW-$clog2(IW/8):0]     WORDS,
    output logic [7:0]                   CSUM
);

    localparam int NB    = IW / 8;         // bytes per instruction word
    localparam int BW    = $clog2(NB);     // byte-offset bits within a word
    localparam int WI    = AW - BW;        // word index width
    localparam int DEPTH = 2 ** WI;

    localparam logic [WI-1:0] IDX_ONE   = WI'(1);
    localparam logic [WI:0]   WORDS_ONE = (WI + 1)'(1);
    localparam logic [BW-1:0] BYTE_ONE  = BW'(1);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_RUN,
        ST_LOAD
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [WI-1:0]   r_clr_idx;
    logic [WI:0]     r_words;     // doubles as the write pointer; bit WI set means full
    logic            r_err;
    logic [BW-1:0]   r_bcnt;      // bytes already held in r_asm
    logic [IW-1:0]   r_asm;       // partially assembled word, upper bytes kept zero
    logic [IW-1:0]   r_q;
    logic            r_mis;
    logic [IW-1:0]   r_mem [DEPTH];

    logic            w_accept;
    logic            w_word_done;
    logic [IW-1:0]   w_word;
    logic            w_we;
    logic [WI-1:0]   w_waddr;
    logic [IW-1:0]   w_wdata;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) r_state <= ST_CLEAR;
        else          r_state <= w_next;
    end

    // Next-state decode plus BUSY / LD_READY, which depend on state alone.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next   = r_state;
        BUSY     = 1'b1;
        LD_READY = 1'b0;
        case (r_state)
            ST_CLEAR: if (r_clr_idx == {WI{1'b1}}) w_next = ST_RUN;
            ST_RUN: begin
                BUSY = 1'b0;
                if (LD_START) w_next = ST_LOAD;
            end
            ST_LOAD: begin
                LD_READY = 1'b1;
                if (LD_VALID && LD_LAST) w_next = ST_RUN;
            end
            default: w_next = ST_CLEAR;
        endcase
    end

    // Byte acceptance, word assembly and the single memory write port.
    always_comb begin
        w_accept    = (r_state == ST_LOAD) && LD_VALID;
        w_word      = r_asm | (IW'(LD_DATA) << {r_bcnt, 3'b000});
        w_word_done = w_accept && (LD_LAST || (r_bcnt == {BW{1'b1}}));
        w_we        = 1'b0;
        w_waddr     = r_clr_idx;
        w_wdata     = '0;
        if (r_state == ST_CLEAR) begin
            w_we = 1'b1;
        end else if (w_word_done && !r_words[WI]) begin
            w_we    = 1'b1;
            w_waddr = r_words[WI-1:0];
            w_wdata = w_word;
        end
    end

    // Clear index walks 0..DEPTH-1 and wraps back to 0 as CLEAR ends.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)                  r_clr_idx <= '0;
        else if (r_state == ST_CLEAR)  r_clr_idx <= r_clr_idx + IDX_ONE;
    end

    // Loader bookkeeping: pointer/word count, overflow flag, byte assembly.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_words <= '0;
            r_err   <= 1'b0;
            r_bcnt  <= '0;
            r_asm   <= '0;
        end else if (r_state == ST_RUN && LD_START) begin
            r_words <= '0;
            r_err   <= 1'b0;
            r_bcnt  <= '0;
            r_asm   <= '0;
        end else if (w_accept) begin
            if (w_word_done) begin
                r_bcnt <= '0;
                r_asm  <= '0;
                if (!r_words[WI]) r_words <= r_words + WORDS_ONE;
                else              r_err   <= 1'b1;
            end else begin
                r_bcnt <= r_bcnt + BYTE_ONE;
                r_asm  <= w_word;
            end
        end
    end

`ifdef IRAM_BOOT_CSUM_EN
    logic [7:0] r_csum;

    // Running byte sum of the current load, overflow bytes included.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)                          r_csum <= '0;
        else if (r_state == ST_RUN && LD_START) r_csum <= '0;
        else if (w_accept)                     r_csum <= r_csum + LD_DATA;
    end

    assign CSUM = r_csum;
`else
    assign CSUM = '0;
`endif

    // Registered fetch; NOP (zero) whenever the memory is not in RUN.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_q   <= '0;
            r_mis <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_q   <= r_mem[ADDR[AW-1:BW]];
            r_mis <= |ADDR[BW-1:0];
        end else begin
            r_q   <= '0;
            r_mis <= 1'b0;
        end
    end

    // Memory array write port.
    // NOTE: the array has no reset; CLEAR zeroes it word by word after reset instead.
    always_ff @(posedge CLK) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end

    assign Q        = r_q;
    assign MISALIGN = r_mis;
    assign LOAD_ERR = r_err;
    assign WORDS    = r_words;

endmodule

// File: tb/tb_iram_boot.sv
// tb_iram_boot: randomized scoreboard bench for iram_boot (IW=16, AW=8).
// Fetch expectations are queued when issued and popped by a monitor when Q is due.
`timescale 1ns/1ps

module tb_iram_boot;

    localparam int IW    = 16;
    localparam int AW    = 8;
    localparam int NB    = IW / 8;
    localparam int BW    = $clog2(NB);
    localparam int WI    = AW - BW;
    localparam int DEPTH = 2 ** WI;

    logic            CLK      = 1'b0;
    logic            RESET_N  = 1'b1;
    logic [AW-1:0]   ADDR     = '0;
    logic            LD_START = 1'b0;
    logic            LD_VALID = 1'b0;
    logic [7:0]      LD_DATA  = '0;
    logic            LD_LAST  = 1'b0;
    logic [IW-1:0]   Q;
    logic            MISALIGN;
    logic            BUSY;
    logic            LD_READY;
    logic            LOAD_ERR;
    logic [WI:0]     WORDS;
    logic [7:0]      CSUM;

    iram_boot #(.IW(IW), .AW(AW)) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .ADDR     (ADDR),
        .Q        (Q),
        .MISALIGN (MISALIGN),
        .BUSY     (BUSY),
        .LD_START (LD_START),
        .LD_VALID (LD_VALID),
        .LD_DATA  (LD_DATA),
        .LD_LAST  (LD_LAST),
        .LD_READY (LD_READY),
        .LOAD_ERR (LOAD_ERR),
        .WORDS    (WORDS),
        .CSUM     (CSUM)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [IW-1:0] q;
        logic          mis;
    } exp_t;

    exp_t          sb[$];
    logic [IW-1:0] ref_mem [DEPTH];
    logic [7:0]    ld_bytes[$];
    int            exp_words;
    logic          exp_err;
    logic [7:0]    exp_csum;
    logic          tb_rd = 1'b0;
    logic          rd_d  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Q is due one clock after a fetch is issued.
    always @(posedge CLK) rd_d <= tb_rd;

    // Monitor: pop and compare whenever a fetch result is presented.
    always @(negedge CLK) begin
        if (rd_d) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("fetch_q", 32'(Q), 32'(e.q));
                check("fetch_misalign", 32'(MISALIGN), 32'(e.mis));
            end
        end
    end

    task automatic fetch(input logic [AW-1:0] a);
        exp_t e;
        @(posedge CLK);
        #1;
        ADDR  = a;
        tb_rd = 1'b1;
        e.q   = ref_mem[a[AW-1:BW]];
        e.mis = (a[BW-1:0] != '0);
        sb.push_back(e);
    endtask

    task automatic fetch_done();
        @(posedge CLK);
        #1;
        tb_rd = 1'b0;
        repeat (2) @(negedge CLK);
        check("sb_drain", sb.size(), 0);
    endtask

    // Reference: bytes fill words in order, little-endian, zero-padded; bytes past
    // the last word are dropped but still summed.
    task automatic model_load();
        int n;
        int nw;
        logic [7:0] sum;
        n   = ld_bytes.size();
        nw  = (n + NB - 1) / NB;
        sum = '0;
        for (int w = 0; w < nw && w < DEPTH; w++) ref_mem[w] = '0;
        for (int i = 0; i < n; i++) begin
            if (i / NB < DEPTH) ref_mem[i / NB][8 * (i % NB) +: 8] = ld_bytes[i];
            sum = sum + ld_bytes[i];
        end
        exp_words = (nw > DEPTH) ? DEPTH : nw;
        exp_err   = (nw > DEPTH);
`ifdef IRAM_BOOT_CSUM_EN
        exp_csum  = sum;
`else
        exp_csum  = 8'h00;
`endif
    endtask

    task automatic check_status(input string tag);
        check({tag, "_busy"},     32'(BUSY),     32'd0);
        check({tag, "_ld_ready"}, 32'(LD_READY), 32'd0);
        check({tag, "_words"},    32'(WORDS),    32'(exp_words));
        check({tag, "_load_err"}, 32'(LOAD_ERR), 32'(exp_err));
        check({tag, "_csum"},     32'(CSUM),     32'(exp_csum));
    endtask

    task automatic do_load(input string tag, input int max_gap);
        model_load();
        @(posedge CLK);
        #1 LD_START = 1'b1;
        @(posedge CLK);
        #1 LD_START = 1'b0;
        for (int i = 0; i < ld_bytes.size(); i++) begin
            repeat ($urandom_range(0, max_gap)) begin
                LD_VALID = 1'b0;
                @(posedge CLK);
                #1;
            end
            LD_VALID = 1'b1;
            LD_DATA  = ld_bytes[i];
            LD_LAST  = (i == ld_bytes.size() - 1);
            @(negedge CLK);
            check({tag, "_ld_ready_hi"}, 32'(LD_READY), 32'd1);
            @(posedge CLK);
            #1;
        end
        LD_VALID = 1'b0;
        LD_LAST  = 1'b0;
        @(negedge CLK);
        check_status(tag);
    endtask

    // Counts negedges with BUSY high; optionally pulses LD_START during CLEAR.
    task automatic wait_clear(input string tag, input int pulse_at);
        int cnt;
        cnt = 0;
        while (cnt < 1000) begin
            @(negedge CLK);
            if (!BUSY) break;
            cnt++;
            LD_START = (cnt == pulse_at);
        end
        LD_START = 1'b0;
        check({tag, "_clear_cycles"}, cnt, DEPTH);
    endtask

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int w = 0; w < DEPTH; w++) ref_mem[w] = '0;
        exp_words = 0;
        exp_err   = 1'b0;
        exp_csum  = 8'h00;

        // Reset values, asserted asynchronously before any clock edge.
        #2 RESET_N = 1'b0;
        #1;
        check("rst_busy",     32'(BUSY),     32'd1);
        check("rst_ld_ready", 32'(LD_READY), 32'd0);
        check("rst_q",        32'(Q),        32'd0);
        check("rst_misalign", 32'(MISALIGN), 32'd0);
        check("rst_load_err", 32'(LOAD_ERR), 32'd0);
        check("rst_words",    32'(WORDS),    32'd0);
        check("rst_csum",     32'(CSUM),     32'd0);
        repeat (3) @(posedge CLK);
        #1 RESET_N = 1'b1;
        wait_clear("boot", 0);
        check_status("boot");
        fetch(8'h10);
        fetch(8'hFE);
        fetch_done();

        // Basic two-word load.
        ld_bytes = '{8'h91, 8'hF4, 8'h49, 8'hF2};
        do_load("basic", 2);
        check("basic_words_lit", 32'(WORDS), 32'd2);
        fetch(8'h00);
        fetch(8'h02);
        fetch_done();

        // Partial final word, then misaligned and aligned fetches.
        ld_bytes = '{8'h3F, 8'h55, 8'h01};
        do_load("partial", 1);
        fetch(8'h03);
        fetch(8'h04);
        fetch(8'h00);
        fetch_done();

        // Randomized loads and fetches; status must hold through RUN.
        for (int t = 0; t < 4; t++) begin
            int n;
            n = $urandom_range(1, 24);
            ld_bytes.delete();
            for (int i = 0; i < n; i++) ld_bytes.push_back(8'($urandom));
            do_load("rand", 3);
            for (int k = 0; k < 8; k++) fetch(AW'($urandom_range(0, 31)));
            fetch_done();
            check_status("rand_hold");
        end

        // Overflow: 258 bytes into a 128-word memory.
        ld_bytes.delete();
        for (int i = 0; i < 258; i++) ld_bytes.push_back(8'($urandom));
        do_load("ovf", 1);
        check("ovf_err_lit",   32'(LOAD_ERR), 32'd1);
        check("ovf_words_lit", 32'(WORDS),    32'd128);
        fetch(8'h00);
        fetch(8'h01);
        fetch(8'hFE);
        fetch_done();

        // Abort: reset after three accepted bytes; LD_START during CLEAR ignored.
        @(posedge CLK);
        #1 LD_START = 1'b1;
        @(posedge CLK);
        #1 LD_START = 1'b0;
        for (int i = 0; i < 3; i++) begin
            LD_VALID = 1'b1;
            LD_DATA  = 8'($urandom);
            @(posedge CLK);
            #1;
        end
        LD_VALID = 1'b0;
        check("abort_words_pre", 32'(WORDS), 32'd1);
        RESET_N = 1'b0;
        #1;
        check("abort_busy",     32'(BUSY),     32'd1);
        check("abort_ld_ready", 32'(LD_READY), 32'd0);
        check("abort_words",    32'(WORDS),    32'd0);
        check("abort_load_err", 32'(LOAD_ERR), 32'd0);
        check("abort_q",        32'(Q),        32'd0);
        repeat (2) @(posedge CLK);
        #1 RESET_N = 1'b1;
        for (int w = 0; w < DEPTH; w++) ref_mem[w] = '0;
        exp_words = 0;
        exp_err   = 1'b0;
        exp_csum  = 8'h00;
        wait_clear("abort", 20);
        repeat (3) begin
            @(negedge CLK);
            check_status("abort_idle");
        end
        for (int w = 0; w < DEPTH; w++) fetch(AW'(w * NB));
        fetch_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
